// File: rtl/ahb_fifo_ctrl.sv
// ahb_fifo_ctrl: pointer/flag controller for a DEPTH-entry AHB bridge FIFO bank.
// Optional registered almost-full flag is built when AHB_FIFO_CTRL_AFULL_EN is defined.
module ahb_fifo_ctrl #(
    parameter int DEPTH     = 4,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int AFULL_LVL = 3
) (
    input  logic             fifo_clk,
    input  logic             fifo_rst,
    input  logic             push_vld,
    output logic             push_rdy,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [DEPTH-1:0] entry_create_en,
    output logic [DEPTH-1:0] rd_sel,
    output logic [PTR_W:0]   fifo_cnt,
    output logic             fifo_full,
`ifdef AHB_FIFO_CTRL_AFULL_EN
    output logic             fifo_empty,
    output logic             fifo_afull
`else
    output logic             fifo_empty
`endif
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    if ((DEPTH < 2) || (DEPTH != (1 << PTR_W)) ||
        (AFULL_LVL < 1) || (AFULL_LVL >= DEPTH)) begin : g_param_err
        $error("ahb_fifo_ctrl: bad DEPTH/PTR_W/AFULL_LVL");
    end

    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q;
    logic [PTR_W:0] rd_ptr_d;
    logic           push_acc;
    logic           pop_acc;
    logic           lo_eq;

    // Extra MSB distinguishes full from empty when the low bits match
    assign lo_eq      = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_empty = lo_eq && (wr_ptr_q[PTR_W] == rd_ptr_q[PTR_W]);
    assign fifo_full  = lo_eq && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;

    assign push_rdy = ~fifo_full;
    assign pop_vld  = ~fifo_empty;
    assign push_acc = push_vld & push_rdy;
    assign pop_acc  = pop_vld & pop_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (fifo_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_dec
        assign entry_create_en[i] =
            push_acc && (wr_ptr_q[PTR_W-1:0] == PTR_W'(i));
        assign rd_sel[i] = (rd_ptr_q[PTR_W-1:0] == PTR_W'(i));
    end

`ifdef AHB_FIFO_CTRL_AFULL_EN
    localparam logic [PTR_W:0] AFULL_CNT = (PTR_W+1)'(AFULL_LVL);

    logic [PTR_W:0] cnt_d;
    logic           afull_q;
    logic           afull_d;

    // Registered from next occupancy so it moves on the same edge as fifo_cnt
    assign cnt_d   = wr_ptr_d - rd_ptr_d;
    assign afull_d = (cnt_d >= AFULL_CNT);

    always_ff @(posedge fifo_clk) begin
        if (fifo_rst) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign fifo_afull = afull_q;
`endif

endmodule

// File: tb/tb_ahb_fifo_ctrl.sv
// tb_ahb_fifo_ctrl: directed self-checking bench for ahb_fifo_ctrl (DEPTH=4).
// Almost-full checks compile in with AHB_FIFO_CTRL_AFULL_EN.
module tb_ahb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_vld;
    logic       pop_rdy;
    logic       push_rdy;
    logic       pop_vld;
    logic [3:0] create_en;
    logic [3:0] rd_sel;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
`ifdef AHB_FIFO_CTRL_AFULL_EN
    logic       afull;
`endif

    int errs = 0;
    int checks = 0;

    logic [7:0] wdata;
    logic [7:0] bank [4];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ahb_fifo_ctrl #(.DEPTH(4), .PTR_W(2), .AFULL_LVL(3)) dut (
        .fifo_clk        (clk),
        .fifo_rst        (rst),
        .push_vld        (push_vld),
        .push_rdy        (push_rdy),
        .pop_vld         (pop_vld),
        .pop_rdy         (pop_rdy),
        .entry_create_en (create_en),
        .rd_sel          (rd_sel),
        .fifo_cnt        (cnt),
        .fifo_full       (full),
`ifdef AHB_FIFO_CTRL_AFULL_EN
        .fifo_empty      (empty),
        .fifo_afull      (afull)
`else
        .fifo_empty      (empty)
`endif
    );

    // Storage bank driven by the controller's write enables
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (create_en[i]) bank[i] <= wdata;
        end
    end

    function automatic logic [7:0] rd_data();
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (rd_sel[i]) d = bank[i];
        end
        return d;
    endfunction

    function automatic logic [6:0] stat();
        return {cnt, full, empty, push_rdy, pop_vld};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push_vld = 1'b0;
        pop_rdy = 1'b0;
        wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (stat() !== 7'b000_0110) begin
            errs++;
            $display("FAIL reset_stat got=%b want=%b", stat(), 7'b000_0110);
        end
        checks++;
        if (create_en !== 4'b0000) begin
            errs++;
            $display("FAIL reset_create_en got=%b want=0000", create_en);
        end
        checks++;
        if (rd_sel !== 4'b0001) begin
            errs++;
            $display("FAIL reset_rd_sel got=%b want=0001", rd_sel);
        end
`ifdef AHB_FIFO_CTRL_AFULL_EN
        checks++;
        if (afull !== 1'b0) begin
            errs++;
            $display("FAIL reset_afull got=%b want=0", afull);
        end
`endif
    endtask

    task automatic test_fill();
        logic [3:0] ce_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [6:0] st_exp [4] = '{7'b000_0110, 7'b001_0011,
                                   7'b010_0011, 7'b011_0011};
        for (int k = 0; k < 4; k++) begin
            push_vld = 1'b1;
            wdata = 8'h10 + 8'(k);
            #1;
            checks++;
            if (create_en !== ce_exp[k]) begin
                errs++;
                $display("FAIL fill_create_en[%0d] got=%b want=%b",
                         k, create_en, ce_exp[k]);
            end
            checks++;
            if (stat() !== st_exp[k]) begin
                errs++;
                $display("FAIL fill_stat[%0d] got=%b want=%b",
                         k, stat(), st_exp[k]);
            end
            exp_q.push_back(wdata);
            tick();
        end
        checks++;
        if (stat() !== 7'b100_1001) begin
            errs++;
            $display("FAIL full_stat got=%b want=1001001", stat());
        end
        wdata = 8'hEE;
        #1;
        checks++;
        if (create_en !== 4'b0000) begin
            errs++;
            $display("FAIL push_full_create_en got=%b want=0000", create_en);
        end
        tick();
        push_vld = 1'b0;
        checks++;
        if (cnt !== 3'd4) begin
            errs++;
            $display("FAIL push_full_cnt got=%0d want=4", cnt);
        end
    endtask

    task automatic test_drain();
        logic [3:0] rs_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0] want;
        pop_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rd_sel !== rs_exp[k]) begin
                errs++;
                $display("FAIL drain_rd_sel[%0d] got=%b want=%b",
                         k, rd_sel, rs_exp[k]);
            end
            want = exp_q.pop_front();
            checks++;
            if (rd_data() !== want) begin
                errs++;
                $display("FAIL drain_data[%0d] got=%h want=%h",
                         k, rd_data(), want);
            end
            tick();
        end
        checks++;
        if (stat() !== 7'b000_0110) begin
            errs++;
            $display("FAIL drain_empty got=%b want=0000110", stat());
        end
        tick();
        pop_rdy = 1'b0;
        checks++;
        if ({cnt, rd_sel} !== {3'd0, 4'b0001}) begin
            errs++;
            $display("FAIL pop_empty got=%0d/%b want=0/0001", cnt, rd_sel);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] pv = 8'b1111_1100;
        logic [7:0] pr = 8'b0011_1111;
        logic [3:0] ce_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0001, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0] rs_exp [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                   4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [2:0] cn_exp [8] = '{3'd0, 3'd1, 3'd2, 3'd2,
                                   3'd2, 3'd2, 3'd2, 3'd1};
        logic [7:0] want;
        for (int k = 0; k < 8; k++) begin
            push_vld = pv[7-k];
            pop_rdy = pr[7-k];
            wdata = 8'h20 + 8'(k);
            #1;
            checks++;
            if ({cnt, create_en, rd_sel} !== {cn_exp[k], ce_exp[k], rs_exp[k]}) begin
                errs++;
                $display("FAIL wrap[%0d] cnt/ce/rs got=%0d/%b/%b want=%0d/%b/%b",
                         k, cnt, create_en, rd_sel,
                         cn_exp[k], ce_exp[k], rs_exp[k]);
            end
            if (pr[7-k]) begin
                want = exp_q.pop_front();
                checks++;
                if (rd_data() !== want) begin
                    errs++;
                    $display("FAIL wrap_data[%0d] got=%h want=%h",
                             k, rd_data(), want);
                end
            end
            if (pv[7-k]) exp_q.push_back(wdata);
            tick();
        end
        push_vld = 1'b0;
        pop_rdy = 1'b0;
        checks++;
        if (stat() !== 7'b000_0110) begin
            errs++;
            $display("FAIL wrap_end got=%b want=0000110", stat());
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] want;
        push_vld = 1'b1;
        pop_rdy = 1'b1;
        wdata = 8'h30;
        #1;
        checks++;
        if ({pop_vld, create_en} !== {1'b0, 4'b0100}) begin
            errs++;
            $display("FAIL pp_empty vld/ce got=%b/%b want=0/0100",
                     pop_vld, create_en);
        end
        exp_q.push_back(wdata);
        tick();
        checks++;
        if (cnt !== 3'd1) begin
            errs++;
            $display("FAIL pp_empty_cnt got=%0d want=1", cnt);
        end
        pop_rdy = 1'b0;
        for (int k = 1; k < 4; k++) begin
            wdata = 8'h30 + 8'(k);
            exp_q.push_back(wdata);
            tick();
        end
        pop_rdy = 1'b1;
        wdata = 8'h34;
        #1;
        checks++;
        if ({cnt, push_rdy, create_en} !== {3'd4, 1'b0, 4'b0000}) begin
            errs++;
            $display("FAIL pp_full cnt/rdy/ce got=%0d/%b/%b want=4/0/0000",
                     cnt, push_rdy, create_en);
        end
        want = exp_q.pop_front();
        checks++;
        if (rd_data() !== want) begin
            errs++;
            $display("FAIL pp_full_data got=%h want=%h", rd_data(), want);
        end
        tick();
        push_vld = 1'b0;
        checks++;
        if (cnt !== 3'd3) begin
            errs++;
            $display("FAIL pp_full_cnt got=%0d want=3", cnt);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            want = exp_q.pop_front();
            checks++;
            if (rd_data() !== want) begin
                errs++;
                $display("FAIL no_overwrite[%0d] got=%h want=%h",
                         k, rd_data(), want);
            end
            tick();
        end
        pop_rdy = 1'b0;
        checks++;
        if (stat() !== 7'b000_0110) begin
            errs++;
            $display("FAIL bound_end got=%b want=0000110", stat());
        end
    endtask

    task automatic test_reset_midop();
`ifdef AHB_FIFO_CTRL_AFULL_EN
        logic afull_exp [3] = '{1'b0, 1'b0, 1'b1};
`endif
        push_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wdata = 8'h40 + 8'(k);
            tick();
`ifdef AHB_FIFO_CTRL_AFULL_EN
            checks++;
            if (afull !== afull_exp[k]) begin
                errs++;
                $display("FAIL afull_rise[%0d] got=%b want=%b",
                         k, afull, afull_exp[k]);
            end
`endif
        end
        push_vld = 1'b0;
        checks++;
        if (cnt !== 3'd3) begin
            errs++;
            $display("FAIL midop_pre_cnt got=%0d want=3", cnt);
        end
`ifdef AHB_FIFO_CTRL_AFULL_EN
        pop_rdy = 1'b1;
        tick();
        pop_rdy = 1'b0;
        checks++;
        if ({cnt, afull} !== {3'd2, 1'b0}) begin
            errs++;
            $display("FAIL afull_fall got=%0d/%b want=2/0", cnt, afull);
        end
        push_vld = 1'b1;
        tick();
        push_vld = 1'b0;
        checks++;
        if ({cnt, afull} !== {3'd3, 1'b1}) begin
            errs++;
            $display("FAIL afull_rerise got=%0d/%b want=3/1", cnt, afull);
        end
`endif
        push_vld = 1'b1;
        pop_rdy = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_vld = 1'b0;
        pop_rdy = 1'b0;
        #1;
        checks++;
        if ({stat(), rd_sel} !== {7'b000_0110, 4'b0001}) begin
            errs++;
            $display("FAIL midop_reset got=%b/%b want=0000110/0001",
                     stat(), rd_sel);
        end
`ifdef AHB_FIFO_CTRL_AFULL_EN
        checks++;
        if (afull !== 1'b0) begin
            errs++;
            $display("FAIL midop_afull got=%b want=0", afull);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_boundaries();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
